// File: rtl/sram_burst_controller.sv
// SRAM controller: single-word writes and naturally aligned burst reads,
// with per-word wait timing and a registered wide read result.
module sram_burst_controller #(
  parameter int DATA_W           = 32,
  parameter int SRAM_ADDR_W      = 17,
  parameter int SRAM_WAIT_CYCLES = 5,
  parameter int BURST_LEN        = 2,
  parameter int BASE_ADDR        = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_en,
  input  logic                          read_en,
  input  logic [31:0]                   address,
  input  logic [DATA_W-1:0]             writeData,
  output logic [BURST_LEN*DATA_W-1:0]   readData,
  output logic                          ready,
  inout  wire  [DATA_W-1:0]             SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0]        SRAM_ADDR,
  output logic                          SRAM_UB_N,
  output logic                          SRAM_LB_N,
  output logic                          SRAM_CE_N,
  output logic                          SRAM_OE_N,
  output logic                          SRAM_WE_N
);

  localparam int CNT_W  = $clog2(SRAM_WAIT_CYCLES + 1);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]       LAST_CNT   = CNT_W'(SRAM_WAIT_CYCLES - 1);
  localparam logic [BEAT_W-1:0]      LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [SRAM_ADDR_W-1:0] BURST_MSK  = SRAM_ADDR_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [SRAM_ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]              wdata_q, wdata_d;
  logic [BURST_LEN-1:0][DATA_W-1:0] rd_q, rd_d;
  logic                           we_n_q, we_n_d;
  logic [SRAM_ADDR_W-1:0]         req_waddr;

  // Byte offset from BASE_ADDR to word address; wraps silently.
  assign req_waddr = SRAM_ADDR_W'((address - 32'(BASE_ADDR)) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        beat_d = '0;
        if (write_en) begin
          addr_d  = req_waddr;
          wdata_d = writeData;
          state_d = WRITE;
        end else if (read_en) begin
          addr_d  = req_waddr;
          state_d = READ;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == LAST_CNT) begin
          rd_d[beat_q] = SRAM_DQ;
          cnt_d        = '0;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobe is low for all but the last count of a write (data hold cycle).
    we_n_d = !((state_d == WRITE) && (cnt_d != LAST_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      we_n_q  <= we_n_d;
    end
  end

  always_comb begin
    case (state_q)
      IDLE:    ready = !(write_en || read_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_ADDR = (state_q == READ) ? ((addr_q & ~BURST_MSK) | SRAM_ADDR_W'(beat_q))
                                       : addr_q;
  assign SRAM_DQ   = (state_q == WRITE) ? wdata_q : 'z;
  assign SRAM_WE_N = we_n_q;
  assign readData  = rd_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_burst_controller.sv
// Directed bench for sram_burst_controller with a behavioural SRAM on the pins.
module tb_sram_burst_controller;
  localparam int DW = 32;
  localparam int AW = 17;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [31:0]   address = '0;
  logic [DW-1:0] writeData = '0;
  wire  [BL*DW-1:0] readData;
  wire           ready;
  wire  [DW-1:0] SRAM_DQ;
  wire  [AW-1:0] SRAM_ADDR;
  wire           ub_n, lb_n, ce_n, oe_n, we_n;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          model_drive = 1'b0;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int nvec = 0;
  int nerr = 0;

  sram_burst_controller dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .address(address), .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus only when the bench enables it, writes while WE_N low.
  assign SRAM_DQ = model_drive ? mem[SRAM_ADDR] : 'z;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!we_n) mem[SRAM_ADDR] <= SRAM_DQ;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", ready); end
    nvec++; if (we_n !== 1'b1) begin nerr++; $display("FAIL reset_we_n: got %b want 1", we_n); end
    nvec++; if (readData !== 64'h0) begin nerr++; $display("FAIL reset_readData: got %h want 0", readData); end
    nvec++; if (SRAM_ADDR !== 17'h0) begin nerr++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
  endtask

  task automatic test_write();
    model_drive = 1'b0;
    write_en = 1'b1; address = 32'd1032; writeData = 32'hDEADBEEF;
    #1;
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL write_c0_ready: got %b want 0", ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) write_en = 1'b0;
      if (k <= 5) begin
        nvec++; if (SRAM_ADDR !== 17'd2) begin nerr++; $display("FAIL write_addr c%0d: got %h want 2", k, SRAM_ADDR); end
        nvec++; if (we_n !== (k == 5)) begin nerr++; $display("FAIL write_we_n c%0d: got %b want %b", k, we_n, (k == 5)); end
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL write_busy c%0d: got %b want 0", k, ready); end
      end else begin
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL write_done c6: got %b want 1", ready); end
      end
    end
    nvec++; if (mem[2] !== 32'hDEADBEEF) begin nerr++; $display("FAIL write_mem: got %h want deadbeef", mem[2]); end
    // Bus must be released once idle: the model's zero must come through untouched.
    preload(17'd2, 32'h0);
    model_drive = 1'b1;
    #1;
    nvec++; if (SRAM_DQ !== 32'h0) begin nerr++; $display("FAIL write_dq_release: got %h want 0", SRAM_DQ); end
  endtask

  task automatic test_burst_read();
    preload(17'd2, 32'h11111111);
    preload(17'd3, 32'h22222222);
    model_drive = 1'b1;
    read_en = 1'b1; address = 32'd1036;
    #1;
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL read_c0_ready: got %b want 0", ready); end
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) read_en = 1'b0;
      if (k <= 10) begin
        nvec++; if (SRAM_ADDR !== ((k <= 5) ? 17'd2 : 17'd3)) begin nerr++; $display("FAIL read_addr c%0d: got %h want %h", k, SRAM_ADDR, ((k <= 5) ? 17'd2 : 17'd3)); end
        nvec++; if (we_n !== 1'b1) begin nerr++; $display("FAIL read_we_n c%0d: got %b want 1", k, we_n); end
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL read_busy c%0d: got %b want 0", k, ready); end
      end else begin
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL read_done c11: got %b want 1", ready); end
        nvec++; if (readData !== 64'h22222222_11111111) begin nerr++; $display("FAIL read_data: got %h want 2222222211111111", readData); end
      end
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    model_drive = 1'b0;
    write_en = 1'b1; read_en = 1'b1; address = 32'd1024; writeData = 32'hA5A5A5A5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin write_en = 1'b0; read_en = 1'b0; end
      if (k <= 5) begin
        nvec++; if (we_n !== (k == 5)) begin nerr++; $display("FAIL simul_we_n c%0d: got %b want %b", k, we_n, (k == 5)); end
      end else begin
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL simul_done c6: got %b want 1", ready); end
      end
    end
    nvec++; if (mem[0] !== 32'hA5A5A5A5) begin nerr++; $display("FAIL simul_mem: got %h want a5a5a5a5", mem[0]); end
    nvec++; if (readData !== 64'h22222222_11111111) begin nerr++; $display("FAIL simul_readData: got %h want 2222222211111111", readData); end
    model_drive = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    read_en = 1'b1; address = 32'd1036;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) read_en = 1'b0;
      nvec++; if (we_n !== 1'b1) begin nerr++; $display("FAIL rstmid_we_n c%0d: got %b want 1", k, we_n); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    nvec++; if (readData !== 64'h0) begin nerr++; $display("FAIL rstmid_readData: got %h want 0", readData); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      nvec++; if (we_n !== 1'b1 || ready !== 1'b1) begin nerr++; $display("FAIL rstmid_idle: got we_n=%b ready=%b want 1/1", we_n, ready); end
    end
    preload(17'd2, 32'h55555555);
    read_en = 1'b1; address = 32'd1032;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) read_en = 1'b0;
    end
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rstmid_reread_ready: got %b want 1", ready); end
    nvec++; if (readData !== 64'h22222222_55555555) begin nerr++; $display("FAIL rstmid_reread_data: got %h want 2222222255555555", readData); end
  endtask

  task automatic test_back_to_back();
    preload(17'd4, 32'h33333333);
    preload(17'd5, 32'h44444444);
    preload(17'h1FFFE, 32'h66666666);
    preload(17'h1FFFF, 32'h77777777);
    read_en = 1'b1; address = 32'd1040;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k == 1) begin
        nvec++; if (SRAM_ADDR !== 17'd4) begin nerr++; $display("FAIL b2b_addr c1: got %h want 4", SRAM_ADDR); end
      end
      if (k == 11) begin
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL b2b_done1: got %b want 1", ready); end
        nvec++; if (readData !== 64'h44444444_33333333) begin nerr++; $display("FAIL b2b_data1: got %h want 4444444433333333", readData); end
        address = 32'd1020;
      end
      if (k == 12) begin
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL b2b_restart: got %b want 0", ready); end
      end
      if (k == 13) begin
        read_en = 1'b0;
        nvec++; if (SRAM_ADDR !== 17'h1FFFE) begin nerr++; $display("FAIL wrap_addr0: got %h want 1fffe", SRAM_ADDR); end
      end
      if (k == 18) begin
        nvec++; if (SRAM_ADDR !== 17'h1FFFF) begin nerr++; $display("FAIL wrap_addr1: got %h want 1ffff", SRAM_ADDR); end
      end
      if (k == 22) begin
        nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL b2b_busy c22: got %b want 0", ready); end
      end
      if (k == 23) begin
        nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL b2b_done2: got %b want 1", ready); end
        nvec++; if (readData !== 64'h77777777_66666666) begin nerr++; $display("FAIL wrap_data: got %h want 7777777766666666", readData); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_burst_read();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
